// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler
//  In-order update queue between branch commit (two slots per cycle) and the
//  single update port of the local branch-prediction counter table.
//  Optional feature macro: BP_UPD_BYPASS_EN -- forwards the next value of the
//  youngest queued update for pred_pc onto the prediction read path.
module bp_update_scheduler #(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      c0_valid,
    input  logic [PC_W-1:0]           c0_pc,
    input  logic                      c0_taken,
    input  logic [1:0]                c0_counter,
    input  logic                      c1_valid,
    input  logic [PC_W-1:0]           c1_pc,
    input  logic                      c1_taken,
    input  logic [1:0]                c1_counter,
    output logic                      commit_ready,
    output logic                      tbl_upd_valid,
    output logic [PC_W-1:0]           tbl_upd_pc,
    output logic                      tbl_upd_taken,
    output logic [1:0]                tbl_upd_counter,
    input  logic                      tbl_upd_ready,
    input  logic                      flush,
    input  logic [PC_W-1:0]           pred_pc,
    input  logic [1:0]                tbl_pred_counter,
    output logic [1:0]                pred_counter,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [1:0]      counter;
    } updEntry_t;

    updEntry_t        mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    updEntry_t        c0Entry;
    updEntry_t        c1Entry;
    updEntry_t        headEntry;
    logic             acceptCommit;
    logic             dropCommit;
    logic             deq;
    logic [1:0]       enqN;
    logic [PTR_W-1:0] c1Slot;

    assign c0Entry   = '{pc: c0_pc, taken: c0_taken, counter: c0_counter};
    assign c1Entry   = '{pc: c1_pc, taken: c1_taken, counter: c1_counter};
    assign headEntry = mem[rdPtr];

    // Space check uses only the registered occupancy, so a same-cycle pop never opens the gate
    assign commit_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
    assign q_count      = count;

    // Head presentation to the table; flush masks the head for the cycle it is asserted
    assign tbl_upd_valid   = (count != '0) & ~flush;
    assign tbl_upd_pc      = headEntry.pc;
    assign tbl_upd_taken   = headEntry.taken;
    assign tbl_upd_counter = headEntry.counter;

    // Enqueue/dequeue decode; c1 lands right behind c0, or at the tail if c0 is idle
    always_comb begin
        acceptCommit = commit_ready & ~flush;
        dropCommit   = (c0_valid | c1_valid) & ~commit_ready & ~flush;
        enqN         = acceptCommit ? (2'(c0_valid) + 2'(c1_valid)) : 2'd0;
        deq          = tbl_upd_valid & tbl_upd_ready;
        c1Slot       = wrPtr + PTR_W'(c0_valid);
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            count <= '0;
            rdPtr <= wrPtr;
        end else begin
            count <= count + CNT_W'(enqN) - CNT_W'(deq);
            rdPtr <= rdPtr + PTR_W'(deq);
            wrPtr <= wrPtr + PTR_W'(enqN);
            if (dropCommit) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (acceptCommit) begin
            if (c0_valid) begin
                mem[wrPtr] <= c0Entry;
            end
            if (c1_valid) begin
                mem[c1Slot] <= c1Entry;
            end
        end
    end

`ifdef BP_UPD_BYPASS_EN
    function automatic logic [1:0] nextCounter(input logic taken, input logic [1:0] c);
        if (taken) begin
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        end
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    logic [PTR_W-1:0] byIdx;

    // Scan oldest to youngest so the youngest matching queued update wins
    always_comb begin
        pred_counter = tbl_pred_counter;
        byIdx        = rdPtr;
        for (int i = 0; i < DEPTH; i++) begin
            byIdx = rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[byIdx].pc == pred_pc)) begin
                pred_counter = nextCounter(mem[byIdx].taken, mem[byIdx].counter);
            end
        end
    end
`else
    logic unusedPredPc;

    // Without forwarding the table value passes straight through
    assign pred_counter = tbl_pred_counter;
    assign unusedPredPc = ^pred_pc;
`endif

endmodule
